// File: rtl/tube_drain_pkg.sv
// Shared types for the tube receive path: the entry that rides the tube and
// the width helper used for credit and occupancy counters.
package tube_drain_pkg;

    typedef struct packed {
        logic       valid;
        logic [7:0] payload;
    } tube_entry_t;

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tube_drain_chk.sv
// Simulation checker: every launch must surface at the tube bottom exactly
// TUBE_DEPTH cycles later.
module tube_drain_chk #(
    parameter int TUBE_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    input logic launch_i,
    input logic arrive_i
);
    logic [TUBE_DEPTH-1:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[TUBE_DEPTH-2:0], launch_i};
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!hist_q[TUBE_DEPTH-1] || arrive_i);
        end
    end

endmodule

// File: rtl/tube_drain_fifo.sv
// Synchronous FIFO for tube entries; a push into a full FIFO is only
// accepted when a pop frees the slot in the same cycle.
module tube_drain_fifo
    import tube_drain_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = tube_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           din_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [credit_w(DEPTH)-1:0] count_o,
    output T                           head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = credit_w(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Head reads as all-zero while empty so stale slots never leak out.
    always_comb begin
        if (empty_o) begin
            head_o = '0;
        end else begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/tube_drain.sv
// Tube receive end: buffers entries leaving the tube and returns launch
// credits so that in-flight plus buffered entries never exceed the FIFO.
module tube_drain
    import tube_drain_pkg::*;
#(
    parameter int  TUBE_DEPTH = 4,
    parameter int  FIFO_DEPTH = 8,
    parameter type T          = tube_entry_t
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            launch,
    output logic                            launch_ok,
    input  T                                tube_out,
    output T                                out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [credit_w(FIFO_DEPTH)-1:0] credits,
    output logic                            err_overflow,
    output logic                            err_launch
);
    localparam int            CW      = credit_w(FIFO_DEPTH);
    localparam logic [CW:0]   POOL    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] POOL_CW = CW'(FIFO_DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_s;
    logic [CW:0]   used_s;
    logic          err_ov_q, err_ov_d;
    logic          err_la_q, err_la_d;
    logic          full_s, empty_s, arrive_s, pop_s, dec_s;
    T              head_s;

    assign arrive_s     = tube_out.valid;
    assign pop_s        = ~empty_s & out_ready;
    assign out_valid    = ~empty_s;
    assign out          = head_s;
    assign err_overflow = err_ov_q;
    assign err_launch   = err_la_q;

    tube_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (T)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (arrive_s),
        .pop_i   (pop_s),
        .din_i   (tube_out),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s),
        .head_o  (head_s)
    );

    // An illegal launch can oversubscribe the pool; credits floor at zero.
    always_comb begin
        used_s = {1'b0, count_s} + {1'b0, inflight_q};
        if (used_s >= POOL) begin
            credits = '0;
        end else begin
            credits = CW'(POOL - used_s);
        end
        launch_ok = (credits != '0);
    end

    always_comb begin
        dec_s = arrive_s & (inflight_q != '0);
        case ({launch, dec_s})
            2'b10:   inflight_d = (inflight_q == POOL_CW) ? inflight_q : inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        err_la_d = err_la_q | (launch & ~launch_ok) | (arrive_s & (inflight_q == '0));
        err_ov_d = err_ov_q | (arrive_s & full_s & ~pop_s);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            err_ov_q   <= 1'b0;
            err_la_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_ov_q   <= err_ov_d;
            err_la_q   <= err_la_d;
        end
    end

    tube_drain_chk #(
        .TUBE_DEPTH (TUBE_DEPTH)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .launch_i (launch),
        .arrive_i (arrive_s)
    );

endmodule
